axis_fan_out_pkt: RTL and testbench

AXIS_FAN_OUT_PKT -- requirements
Module: axis_fan_out_pkt

---
 rtl/axis_fan_out_pkt_if.sv | 27 ++
 rtl/axis_fan_out_pkt.sv | 132 +++++++++++++
 tb/tb_axis_fan_out_pkt.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_fan_out_pkt_if.sv
// Stream bundle for the packet fan-out: one slave input stream, NUM_FANOUT packed master streams.
// The slave modport is the fan-out block's view; the master modport is the surrounding environment.
interface axis_fan_out_pkt_if #(
    parameter int NUM_FANOUT = 6,
    parameter int DATA_WIDTH = 256
);
    logic                             s_axis_tvalid;
    logic                             s_axis_tready;
    logic [DATA_WIDTH-1:0]            s_axis_tdata;
    logic [NUM_FANOUT-1:0]            s_axis_tuser;
    logic                             s_axis_tlast;
    logic [NUM_FANOUT-1:0]            m_axis_tvalid;
    logic [NUM_FANOUT-1:0]            m_axis_tready;
    logic [NUM_FANOUT*DATA_WIDTH-1:0] m_axis_tdata;
    logic [NUM_FANOUT-1:0]            m_axis_tlast;
    logic                             err_no_dest;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, err_no_dest
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, err_no_dest
    );
endinterface

// File: rtl/axis_fan_out_pkt.sv
// Packet-locked AXI-Stream fan-out: first-beat tuser mask routes the whole packet into per-channel FWFT FIFOs.
// 1-cycle accept-to-valid; s_axis_tready drops while any selected FIFO is full (all-or-none write).
module axis_fan_out_pkt #(
    parameter int NUM_FANOUT = 6,
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 4,
    parameter bit BROADCAST  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    axis_fan_out_pkt_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                state_q, state_d;
    logic [NUM_FANOUT-1:0] mask_q, mask_d;
    logic                  err_q, err_d;

    logic [AW-1:0] wr_ptr_q [NUM_FANOUT];
    logic [AW-1:0] wr_ptr_d [NUM_FANOUT];
    logic [AW-1:0] rd_ptr_q [NUM_FANOUT];
    logic [AW-1:0] rd_ptr_d [NUM_FANOUT];
    logic [CW-1:0] count_q  [NUM_FANOUT];
    logic [CW-1:0] count_d  [NUM_FANOUT];

    // Entry layout: {tlast, tdata}; storage carries no reset.
    logic [DATA_WIDTH:0] mem_q [NUM_FANOUT][FIFO_DEPTH];

    logic [NUM_FANOUT-1:0] eff_mask;
    logic [NUM_FANOUT-1:0] full;
    logic [NUM_FANOUT-1:0] push;
    logic [NUM_FANOUT-1:0] pop;
    logic [NUM_FANOUT-1:0] m_vld;
    logic                  s_rdy;
    logic                  accept;

    always_comb begin
        if (BROADCAST) begin
            eff_mask = '1;
        end else if (state_q == IDLE) begin
            eff_mask = bus.s_axis_tuser;
        end else begin
            eff_mask = mask_q;
        end
    end

    always_comb begin
        full  = '0;
        m_vld = '0;
        for (int i = 0; i < NUM_FANOUT; i++) begin
            full[i]  = (count_q[i] == CW'(FIFO_DEPTH));
            m_vld[i] = (count_q[i] != '0);
        end
    end

    // An empty mask selects nothing, so the stream drains freely.
    assign s_rdy  = ~|(eff_mask & full);
    assign accept = bus.s_axis_tvalid & s_rdy;
    assign push   = {NUM_FANOUT{accept}} & eff_mask;
    assign pop    = m_vld & bus.m_axis_tready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                err_d = (eff_mask == '0);
                if (!bus.s_axis_tlast) begin
                    state_d = IN_PKT;
                    mask_d  = bus.s_axis_tuser;
                end
            end else if (bus.s_axis_tlast) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FANOUT; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_FANOUT; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_FANOUT; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FANOUT; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {bus.s_axis_tlast, bus.s_axis_tdata};
            end
        end
    end

    always_comb begin
        bus.m_axis_tdata = '0;
        bus.m_axis_tlast = '0;
        for (int i = 0; i < NUM_FANOUT; i++) begin
            {bus.m_axis_tlast[i], bus.m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]} = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign bus.m_axis_tvalid = m_vld;
    assign bus.s_axis_tready = s_rdy;
    assign bus.err_no_dest   = err_q;

endmodule

// File: tb/tb_axis_fan_out_pkt.sv
// Bench for axis_fan_out_pkt: randomized packets scored against per-channel expected queues,
// plus directed unicast, packet lock, backpressure, empty-mask, reset and broadcast cases.
module tb_axis_fan_out_pkt;
    localparam int NF    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NF2   = 4;
    localparam int DW2   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_fan_out_pkt_if #(.NUM_FANOUT(NF), .DATA_WIDTH(DW)) bus ();
    axis_fan_out_pkt_if #(.NUM_FANOUT(NF2), .DATA_WIDTH(DW2)) bus2 ();

    axis_fan_out_pkt #(.NUM_FANOUT(NF), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BROADCAST(1'b0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    axis_fan_out_pkt #(.NUM_FANOUT(NF2), .DATA_WIDTH(DW2), .FIFO_DEPTH(DEPTH), .BROADCAST(1'b1))
        dut_bc (.clk(clk), .rst(rst), .bus(bus2));

    int errors = 0;
    int checks = 0;

    // Reference model: each channel is a queue of {tlast, data} beats the packet owns.
    logic [DW:0]   exp_q [NF][$];
    logic [NF-1:0] pkt_mask = '0;
    bit            err_pending = 1'b0;
    bit            rdy_random  = 1'b0;
    logic [NF-1:0] rdy_fixed   = '1;
    int            accepted    = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        bus.m_axis_tready = '1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_axis_tready = rdy_random ? NF'($urandom | $urandom) : rdy_fixed;
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin
        bit          exp_rdy;
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.s_axis_tvalid) begin
                    exp_rdy = 1'b1;
                    for (int i = 0; i < NF; i++)
                        if (pkt_mask[i] && exp_q[i].size() >= DEPTH) exp_rdy = 1'b0;
                    chk(bus.s_axis_tready == exp_rdy, "s_tready", 64'(bus.s_axis_tready), 64'(exp_rdy));
                end
                for (int i = 0; i < NF; i++) begin
                    chk(bus.m_axis_tvalid[i] == (exp_q[i].size() != 0), $sformatf("m_valid[%0d]", i),
                        64'(bus.m_axis_tvalid[i]), 64'(exp_q[i].size() != 0));
                    if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i] && exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        chk({bus.m_axis_tlast[i], bus.m_axis_tdata[i*DW +: DW]} == e,
                            $sformatf("beat ch%0d", i),
                            64'({bus.m_axis_tlast[i], bus.m_axis_tdata[i*DW +: DW]}), 64'(e));
                    end
                end
                chk(bus.err_no_dest == err_pending, "err_no_dest", 64'(bus.err_no_dest), 64'(err_pending));
                err_pending = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [NF-1:0] tu, input bit last, input bit first);
        bit got = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tuser  = tu;
        bus.s_axis_tlast  = last;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (bus.s_axis_tready) got = 1'b1;
        end
        chk(got, "accept_timeout", 64'(got), 64'd1);
        if (!got) begin
            bus.s_axis_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i < NF; i++)
            if (pkt_mask[i]) exp_q[i].push_back({last, d});
        if (first && pkt_mask == '0) err_pending = 1'b1;
        accepted++;
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    // The whole packet belongs to the mask presented with its first beat.
    task automatic send_pkt(input logic [NF-1:0] m, input logic [NF-1:0] tu_rest, input int len, input int nsend);
        pkt_mask = m;
        for (int b = 0; b < nsend; b++)
            send_beat(DW'($urandom), (b == 0) ? m : tu_rest, b == len - 1, b == 0);
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < NF; i++)
                if (exp_q[i].size() != 0) done = 1'b0;
        end
        chk(done, name, 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        bus.s_axis_tvalid  = 1'b0;
        bus.s_axis_tdata   = '0;
        bus.s_axis_tuser   = '0;
        bus.s_axis_tlast   = 1'b0;
        bus2.s_axis_tvalid = 1'b0;
        bus2.s_axis_tdata  = '0;
        bus2.s_axis_tuser  = '0;
        bus2.s_axis_tlast  = 1'b0;
        bus2.m_axis_tready = '0;

        #1 rst = 1'b1;
        #2;
        chk(bus.m_axis_tvalid == '0, "reset m_valid", 64'(bus.m_axis_tvalid), 64'd0);
        chk(bus.err_no_dest == 1'b0, "reset err", 64'(bus.err_no_dest), 64'd0);
        chk(bus2.m_axis_tvalid == '0, "reset bc m_valid", 64'(bus2.m_axis_tvalid), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send_pkt(6'b000100, 6'b000100, 3, 3);
        wait_drain("drain unicast");
        send_pkt(6'b000001, 6'b100000, 3, 3);
        wait_drain("drain lock");
        send_pkt(6'b000000, 6'b000000, 2, 2);
        wait_drain("drain empty");

        rdy_fixed = 6'b111101;
        @(posedge clk);
        #1;
        acc0 = accepted;
        fork
            send_pkt(6'b000011, 6'b000011, 6, 6);
            begin
                repeat (15) @(negedge clk);
                chk(accepted - acc0 == 4, "bp accepted", 64'(accepted - acc0), 64'd4);
                chk(bus.s_axis_tready == 1'b0, "bp s_tready", 64'(bus.s_axis_tready), 64'd0);
                chk(bus.m_axis_tvalid[1:0] == 2'b10, "bp valids", 64'(bus.m_axis_tvalid[1:0]), 64'b10);
                rdy_fixed = '1;
            end
        join
        chk(accepted - acc0 == 6, "bp total", 64'(accepted - acc0), 64'd6);
        wait_drain("drain bp");

        rdy_random = 1'b1;
        for (int p = 0; p < 60; p++) begin
            logic [NF-1:0] m;
            int len;
            m   = ($urandom_range(0, 6) == 0) ? '0 : NF'($urandom);
            len = $urandom_range(1, 6);
            send_pkt(m, NF'($urandom), len, len);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_random = 1'b0;
        rdy_fixed  = '1;
        wait_drain("drain random");

        rdy_fixed = '0;
        @(posedge clk);
        #1;
        send_pkt(6'b010010, 6'b000000, 4, 2);
        #2 rst = 1'b1;
        #1;
        chk(bus.m_axis_tvalid == '0, "async reset m_valid", 64'(bus.m_axis_tvalid), 64'd0);
        for (int i = 0; i < NF; i++) exp_q[i].delete();
        err_pending = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_fixed = '1;
        send_pkt(6'b001000, 6'b000001, 3, 3);
        wait_drain("drain post-reset");

        bus2.s_axis_tvalid = 1'b1;
        bus2.s_axis_tdata  = 8'hA5;
        bus2.s_axis_tuser  = '0;
        bus2.s_axis_tlast  = 1'b1;
        @(negedge clk);
        chk(bus2.s_axis_tready == 1'b1, "bc s_tready", 64'(bus2.s_axis_tready), 64'd1);
        @(posedge clk);
        #1 bus2.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk(bus2.m_axis_tvalid == 4'hF, "bc m_valid", 64'(bus2.m_axis_tvalid), 64'hF);
        chk(bus2.m_axis_tlast == 4'hF, "bc m_tlast", 64'(bus2.m_axis_tlast), 64'hF);
        chk(bus2.err_no_dest == 1'b0, "bc err", 64'(bus2.err_no_dest), 64'd0);
        for (int i = 0; i < NF2; i++)
            chk(bus2.m_axis_tdata[i*DW2 +: DW2] == 8'hA5, $sformatf("bc data ch%0d", i),
                64'(bus2.m_axis_tdata[i*DW2 +: DW2]), 64'hA5);
        bus2.m_axis_tready = '1;
        @(posedge clk);
        #1;
        chk(bus2.m_axis_tvalid == '0, "bc drained", 64'(bus2.m_axis_tvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
